// File: rtl/sysref_gate_pkg.sv
// Shared types and defaults for the PL SYSREF gate sequencer.
// Holds the FSM state type and the period tolerance helper.
package sysref_gate_pkg;

   typedef enum logic [1:0] {IDLE, ACQ, ALIGN, PASS} state_t;

   localparam int unsigned PERIOD_W_DEF   = 16;
   localparam int unsigned LOCK_CNT_DEF   = 4;
   localparam int unsigned PERIOD_TOL_DEF = 1;
   localparam int unsigned PULSE_W_DEF    = 8;
   localparam int unsigned LOCK_W         = 4;

   function automatic logic period_match(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] tol);
      logic [31:0] d;
      d = (a > b) ? (a - b) : (b - a);
      return (d <= tol);
   endfunction

endpackage

// File: rtl/sysref_period_meter.sv
// Rising-edge detector and saturating period counter for the retimed SYSREF level.
// cur_period is the live count, i.e. the period being measured at a rise.
module sysref_period_meter
   import sysref_gate_pkg::*;
#(
   parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
   input  logic                pl_refclk_m,
   input  logic                rst,
   input  logic                sysref_in,
   output logic                rise,
   output logic                sat,
   output logic [PERIOD_W-1:0] cur_period,
   output logic [PERIOD_W-1:0] period_o
);

   logic                sysref_d;
   logic [PERIOD_W-1:0] cnt;

   assign rise       = sysref_in & ~sysref_d;
   assign sat        = (cnt == '1) & ~rise;
   assign cur_period = cnt;

   always_ff @(posedge pl_refclk_m or posedge rst) begin
      if (rst) begin
         sysref_d <= 1'b0;
         cnt      <= '0;
         period_o <= '0;
      end else begin
         sysref_d <= sysref_in;
         if (rise) begin
            period_o <= cnt;
            cnt      <= PERIOD_W'(1);
         end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sysref_gate_ctrl.sv
// SYSREF lock/align/pass sequencer: measures the period, locks, then gates a
// programmed number of whole pulses onto the DAC/ADC user_sysref outputs.
module sysref_gate_ctrl
   import sysref_gate_pkg::*;
#(
   parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
   parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
   parameter int unsigned PERIOD_TOL = PERIOD_TOL_DEF,
   parameter int unsigned PULSE_W    = PULSE_W_DEF
) (
   input  logic                pl_refclk_m,
   input  logic                rst,
   input  logic                sysref_in,
   input  logic                arm_i,
   input  logic                abort_i,
   input  logic [PULSE_W-1:0]  num_pulses_i,
   input  logic                en_dac_i,
   input  logic                en_adc_i,
   output logic                user_sysref_dac,
   output logic                user_sysref_adc,
   output logic                busy_o,
   output logic                locked_o,
   output logic                done_o,
   output logic                err_timeout_o,
   output logic                err_period_o,
   output logic [PERIOD_W-1:0] period_o
);

   state_t              state, state_n;
   logic                gate_open, gate_n;
   logic [PULSE_W-1:0]  num_lat, num_n, pulse_cnt, pulse_n;
   logic                en_dac_lat, en_dac_n, en_adc_lat, en_adc_n;
   logic [LOCK_W-1:0]   match_cnt, match_n;
   logic                first_seen, first_n;
   logic [PERIOD_W-1:0] ref_period, ref_n, cur_period;
   logic                abort_seen, abort_n;
   logic                locked_n, done_n, err_to_n, err_per_n;
   logic                rise, sat, in_tol, count_done;

   sysref_period_meter #(.PERIOD_W(PERIOD_W)) u_meter (
      .pl_refclk_m (pl_refclk_m),
      .rst         (rst),
      .sysref_in   (sysref_in),
      .rise        (rise),
      .sat         (sat),
      .cur_period  (cur_period),
      .period_o    (period_o)
   );

   assign busy_o     = (state != IDLE);
   assign in_tol     = period_match(32'(cur_period), 32'(ref_period), PERIOD_TOL);
   assign count_done = (num_lat != '0) && (pulse_cnt == num_lat);

   always_comb begin
      state_n   = state;
      gate_n    = gate_open;
      num_n     = num_lat;
      en_dac_n  = en_dac_lat;
      en_adc_n  = en_adc_lat;
      match_n   = match_cnt;
      first_n   = first_seen;
      ref_n     = ref_period;
      pulse_n   = pulse_cnt;
      abort_n   = abort_seen;
      locked_n  = locked_o;
      done_n    = 1'b0;
      err_to_n  = err_timeout_o;
      err_per_n = err_period_o;
      case (state)
         IDLE: begin
            if (arm_i && !abort_i) begin
               num_n     = num_pulses_i;
               en_dac_n  = en_dac_i;
               en_adc_n  = en_adc_i;
               err_to_n  = 1'b0;
               err_per_n = 1'b0;
               locked_n  = 1'b0;
               match_n   = '0;
               first_n   = 1'b0;
               pulse_n   = '0;
               abort_n   = 1'b0;
               state_n   = ACQ;
            end
         end
         ACQ: begin
            if (abort_i) begin
               state_n = IDLE;
            end else if (sat) begin
               err_to_n = 1'b1;
               state_n  = IDLE;
            end else if (rise) begin
               if (!first_seen) begin
                  first_n = 1'b1;
                  ref_n   = cur_period;
               end else if (in_tol) begin
                  match_n = match_cnt + 1'b1;
                  if ((match_cnt + 1'b1) == LOCK_W'(LOCK_CNT)) begin
                     locked_n = 1'b1;
                     state_n  = ALIGN;
                  end
               end else begin
                  match_n = '0;
                  ref_n   = cur_period;
               end
            end
         end
         ALIGN: begin
            if (abort_i) begin
               state_n = IDLE;
            end else if (!sysref_in) begin
               gate_n  = 1'b1;
               state_n = PASS;
            end
         end
         PASS: begin
            abort_n = abort_seen | abort_i;
            if (rise && gate_open) begin
               if (pulse_cnt != '1) pulse_n = pulse_cnt + 1'b1;
               if (!in_tol) err_per_n = 1'b1;
            end
            // The gate only ever closes while the input is low, except on a
            // saturation timeout where the input has stopped toggling anyway.
            if (sat) begin
               err_to_n = 1'b1;
               gate_n   = 1'b0;
               state_n  = IDLE;
            end else if ((count_done || abort_n) && !sysref_in) begin
               gate_n  = 1'b0;
               state_n = IDLE;
               done_n  = count_done & ~abort_n;
            end
         end
      endcase
   end

   always_ff @(posedge pl_refclk_m or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         gate_open       <= 1'b0;
         num_lat         <= '0;
         en_dac_lat      <= 1'b0;
         en_adc_lat      <= 1'b0;
         match_cnt       <= '0;
         first_seen      <= 1'b0;
         ref_period      <= '0;
         pulse_cnt       <= '0;
         abort_seen      <= 1'b0;
         locked_o        <= 1'b0;
         done_o          <= 1'b0;
         err_timeout_o   <= 1'b0;
         err_period_o    <= 1'b0;
         user_sysref_dac <= 1'b0;
         user_sysref_adc <= 1'b0;
      end else begin
         state           <= state_n;
         gate_open       <= gate_n;
         num_lat         <= num_n;
         en_dac_lat      <= en_dac_n;
         en_adc_lat      <= en_adc_n;
         match_cnt       <= match_n;
         first_seen      <= first_n;
         ref_period      <= ref_n;
         pulse_cnt       <= pulse_n;
         abort_seen      <= abort_n;
         locked_o        <= locked_n;
         done_o          <= done_n;
         err_timeout_o   <= err_to_n;
         err_period_o    <= err_per_n;
         user_sysref_dac <= sysref_in & gate_open & en_dac_lat;
         user_sysref_adc <= sysref_in & gate_open & en_adc_lat;
      end
   end

endmodule
